pipe_csel_adder: RTL

PIPE_CSEL_ADDER -- requirements
Module: pipe_csel_adder

---
 rtl/adder_pkg.sv | 12 +
 rtl/csel_block.sv | 17 +
 rtl/pipe_csel_adder.sv | 112 +++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
// Default width/block size and the block-count helper used at elaboration.
package adder_pkg;

    localparam int ADDER_WIDTH = 16;
    localparam int ADDER_BLOCK = 4;

    function automatic int nblk(input int width, input int block);
        return (block > 0) ? width / block : 1;
    endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select slice: both candidate sums and carries for a block.
// Ports: a/b block operands; sum0/c0 assume carry-in 0, sum1/c1 carry-in 1.
module csel_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    output logic [BLOCK-1:0] sum0,
    output logic [BLOCK-1:0] sum1,
    output logic             c0,
    output logic             c1
);

    assign {c0, sum0} = {1'b0, a} + {1'b0, b};
    assign {c1, sum1} = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

endmodule

// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor, one block per stage, valid/ready.
// Ports: Clk, Reset_n; in_valid/in_ready a b cin sub; out_valid/out_ready sum cout ovf.
module pipe_csel_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int BLOCK = ADDER_BLOCK
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = nblk(WIDTH, BLOCK);
    localparam int MSB  = WIDTH - 1;

    if (BLOCK < 1) begin : g_bad_block
        $fatal(1, "pipe_csel_adder: BLOCK must be >= 1");
    end else if (WIDTH % BLOCK != 0) begin : g_bad_width
        $fatal(1, "pipe_csel_adder: WIDTH must be a multiple of BLOCK");
    end

    // Slot 0 is the operand capture register; slot k+1 is stage k's output.
    logic [NBLK:0]    v_q;
    logic [NBLK-1:0]  c_q;
    logic [NBLK-1:0]  c_d;
    logic [WIDTH-1:0] opa_q [NBLK];
    logic [WIDTH-1:0] opb_q [NBLK];
    logic [WIDTH-1:0] s_q   [NBLK];
    logic [WIDTH-1:0] s_d   [NBLK];
    logic             cout_q;
    logic             ovf_q;
    logic             ovf_d;
    logic             en;

    assign en        = !(v_q[NBLK] && !out_ready);
    assign in_ready  = en;
    assign out_valid = v_q[NBLK];
    assign sum       = s_q[NBLK-1];
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        localparam int LO = k * BLOCK;
        logic [BLOCK-1:0] s0;
        logic [BLOCK-1:0] s1;
        logic             c0;
        logic             c1;

        csel_block #(.BLOCK(BLOCK)) u_blk (
            .a    (opa_q[k][LO +: BLOCK]),
            .b    (opb_q[k][LO +: BLOCK]),
            .sum0 (s0),
            .sum1 (s1),
            .c0   (c0),
            .c1   (c1)
        );

        assign c_d[k] = c_q[k] ? c1 : c0;

        // Bits above the finished blocks stay zero, so OR merges the slice.
        if (k == 0) begin : g_first
            assign s_d[k] = WIDTH'(c_q[k] ? s1 : s0);
        end else begin : g_rest
            assign s_d[k] = s_q[k-1] | (WIDTH'(c_q[k] ? s1 : s0) << LO);
        end
    end

    // Carry into the MSB equals a^b^sum at that bit.
    assign ovf_d = opa_q[NBLK-1][MSB] ^ opb_q[NBLK-1][MSB]
                 ^ s_d[NBLK-1][MSB] ^ c_d[NBLK-1];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v_q    <= '0;
            c_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int k = 0; k < NBLK; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                s_q[k]   <= '0;
            end
        end else if (en) begin
            v_q      <= {v_q[NBLK-1:0], in_valid};
            opa_q[0] <= a;
            opb_q[0] <= sub ? ~b : b;
            c_q[0]   <= sub | cin;
            for (int k = 1; k < NBLK; k++) begin
                opa_q[k] <= opa_q[k-1];
                opb_q[k] <= opb_q[k-1];
                c_q[k]   <= c_d[k-1];
            end
            for (int k = 0; k < NBLK; k++) begin
                s_q[k] <= s_d[k];
            end
            cout_q <= c_d[NBLK-1];
            ovf_q  <= ovf_d;
        end
    end

endmodule
